// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 5-stage MIPS core: ID decode, ID/EX/MEM/WB control
// bundles, load-use interlock, branch flush and HLT drain sequencing.
//
// state   | meaning
// RUN     | normal issue from ID
// DRAIN   | HLT accepted; ID held, waiting for EX/MEM/WB to empty
// HALTED  | pipe empty, bubbles only until reset
module pipe_ctrl_unit #(
  parameter int OPCODE_W  = 6,
  parameter int ALUOP_W   = 3,
  parameter int RA_W      = 5,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [RA_W-1:0]     id_rs,
  input  logic [RA_W-1:0]     id_rt,
  input  logic [RA_W-1:0]     id_rd,
  input  logic                ex_br_taken,
  output logic                stall,
  output logic                flush,
  output logic                ex_valid,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic                ex_alusrc,
  output logic                ex_branch,
  output logic                ex_memread,
  output logic [RA_W-1:0]     ex_dst,
  output logic                mem_valid,
  output logic                mem_memread,
  output logic                mem_memwrite,
  output logic                mem_memtoreg,
  output logic [RA_W-1:0]     mem_dst,
  output logic                wb_valid,
  output logic                wb_regwrite,
  output logic                wb_memtoreg,
  output logic [RA_W-1:0]     wb_dst,
  output logic                illegal_op,
  output logic                halted
);

  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SLT   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_HLT   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_SUBI  = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_BNEQZ = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_BEQZ  = OPCODE_W'(13);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t state_q, state_d;

  logic               ex_valid_q, ex_alusrc_q, ex_branch_q, ex_memread_q;
  logic               ex_memwrite_q, ex_memtoreg_q, ex_regwrite_q;
  logic [ALUOP_W-1:0] ex_alu_op_q;
  logic [RA_W-1:0]    ex_dst_q;
  logic               mem_valid_q, mem_memread_q, mem_memwrite_q, mem_memtoreg_q, mem_regwrite_q;
  logic [RA_W-1:0]    mem_dst_q;
  logic               wb_valid_q, wb_regwrite_q, wb_memtoreg_q;
  logic [RA_W-1:0]    wb_dst_q;
  logic               illegal_q, illegal_d;

  logic               d_regwrite, d_memread, d_memwrite, d_memtoreg, d_alusrc, d_branch;
  logic               d_legal, d_halt, uses_rs, uses_rt;
  logic [ALUOP_W-1:0] d_alu_op;
  logic [RA_W-1:0]    d_dst;
  logic               run, ld_use, issue, ex_go;

  always_comb begin
    d_regwrite = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_memtoreg = 1'b0;
    d_alusrc   = 1'b0;
    d_branch   = 1'b0;
    d_alu_op   = ALU_ADD;
    d_dst      = '0;
    d_legal    = 1'b1;
    d_halt     = 1'b0;
    uses_rt    = 1'b0;
    case (id_opcode)
      OP_ADD:   begin d_regwrite = 1'b1; d_dst = id_rd; uses_rt = 1'b1; d_alu_op = ALU_ADD; end
      OP_SUB:   begin d_regwrite = 1'b1; d_dst = id_rd; uses_rt = 1'b1; d_alu_op = ALU_SUB; end
      OP_AND:   begin d_regwrite = 1'b1; d_dst = id_rd; uses_rt = 1'b1; d_alu_op = ALU_AND; end
      OP_OR:    begin d_regwrite = 1'b1; d_dst = id_rd; uses_rt = 1'b1; d_alu_op = ALU_OR;  end
      OP_SLT:   begin d_regwrite = 1'b1; d_dst = id_rd; uses_rt = 1'b1; d_alu_op = ALU_SLT; end
      OP_HLT:   d_halt = 1'b1;
      OP_LW:    begin
        d_regwrite = 1'b1; d_memread = 1'b1; d_memtoreg = 1'b1; d_alusrc = 1'b1; d_dst = id_rt;
      end
      OP_SW:    begin d_memwrite = 1'b1; d_alusrc = 1'b1; uses_rt = 1'b1; end
      OP_ADDI:  begin d_regwrite = 1'b1; d_alusrc = 1'b1; d_dst = id_rt; d_alu_op = ALU_ADD; end
      OP_SUBI:  begin d_regwrite = 1'b1; d_alusrc = 1'b1; d_dst = id_rt; d_alu_op = ALU_SUB; end
      OP_SLTI:  begin d_regwrite = 1'b1; d_alusrc = 1'b1; d_dst = id_rt; d_alu_op = ALU_SLT; end
      OP_BNEQZ, OP_BEQZ: begin d_branch = 1'b1; d_alu_op = ALU_SUB; end
      default:  d_legal = 1'b0;
    endcase
    if (d_dst == '0) d_regwrite = 1'b0;
  end

  assign uses_rs = ~d_halt;
  assign run     = (state_q == ST_RUN);
  assign ld_use  = HAZARD_EN & id_valid & ex_valid_q & ex_memread_q & (ex_dst_q != '0) &
                   ((uses_rs & (id_rs == ex_dst_q)) | (uses_rt & (id_rt == ex_dst_q)));
  assign flush   = ex_br_taken & ex_valid_q & ex_branch_q;
  // A taken branch kills ID, so its load-use stall would only freeze a dead instruction.
  assign stall   = ~run | (ld_use & ~flush);
  assign issue   = run & id_valid & ~flush & ~ld_use;
  assign ex_go   = issue & d_legal & ~d_halt;
  assign illegal_d = issue & ~d_legal;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (id_valid & d_halt & ~flush) state_d = ST_DRAIN;
      ST_DRAIN:  if (~(ex_valid_q | mem_valid_q | wb_valid_q)) state_d = ST_HALTED;
      default:   state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      ex_valid_q     <= 1'b0;
      ex_alu_op_q    <= '0;
      ex_alusrc_q    <= 1'b0;
      ex_branch_q    <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_memtoreg_q  <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_dst_q       <= '0;
      mem_valid_q    <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_dst_q      <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_dst_q       <= '0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ex_valid_q     <= ex_go;
      ex_alu_op_q    <= ex_go ? d_alu_op : '0;
      ex_alusrc_q    <= ex_go & d_alusrc;
      ex_branch_q    <= ex_go & d_branch;
      ex_memread_q   <= ex_go & d_memread;
      ex_memwrite_q  <= ex_go & d_memwrite;
      ex_memtoreg_q  <= ex_go & d_memtoreg;
      ex_regwrite_q  <= ex_go & d_regwrite;
      ex_dst_q       <= ex_go ? d_dst : '0;
      mem_valid_q    <= ex_valid_q;
      mem_memread_q  <= ex_memread_q;
      mem_memwrite_q <= ex_memwrite_q;
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_dst_q      <= ex_dst_q;
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_dst_q       <= mem_dst_q;
      illegal_q      <= illegal_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_alu_op    = ex_alu_op_q;
  assign ex_alusrc    = ex_alusrc_q;
  assign ex_branch    = ex_branch_q;
  assign ex_memread   = ex_memread_q;
  assign ex_dst       = ex_dst_q;
  assign mem_valid    = mem_valid_q;
  assign mem_memread  = mem_memread_q;
  assign mem_memwrite = mem_memwrite_q;
  assign mem_memtoreg = mem_memtoreg_q;
  assign mem_dst      = mem_dst_q;
  assign wb_valid     = wb_valid_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_memtoreg  = wb_memtoreg_q;
  assign wb_dst       = wb_dst_q;
  assign illegal_op   = illegal_q;
  assign halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode latency, load-use stall, branch flush,
// HLT drain, illegal opcode and async reset, with hand-computed expectations.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_br_taken;
  logic       stall, flush;
  logic       ex_valid, ex_alusrc, ex_branch, ex_memread;
  logic [2:0] ex_alu_op;
  logic [4:0] ex_dst;
  logic       mem_valid, mem_memread, mem_memwrite, mem_memtoreg;
  logic [4:0] mem_dst;
  logic       wb_valid, wb_regwrite, wb_memtoreg;
  logic [4:0] wb_dst;
  logic       illegal_op, halted;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alusrc(ex_alusrc),
    .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_dst(ex_dst),
    .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .mem_dst(mem_dst),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_dst(wb_dst), .illegal_op(illegal_op), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int op, input int rs, input int rt, input int rd);
    id_valid  = v;
    id_opcode = op[5:0];
    id_rs     = rs[4:0];
    id_rt     = rt[4:0];
    id_rd     = rd[4:0];
  endtask

  task automatic check_all_zero(input string tag);
    int bits;
    bits = {stall, flush, ex_valid, ex_alusrc, ex_branch, ex_memread, mem_valid,
            mem_memread, mem_memwrite, mem_memtoreg, wb_valid, wb_regwrite,
            wb_memtoreg, illegal_op, halted};
    check({tag, "_bits"}, bits, 0);
    check({tag, "_fields"}, int'(ex_alu_op) + int'(ex_dst) + int'(mem_dst) + int'(wb_dst), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_br_taken = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    #1;
    check_all_zero("reset_async");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check_all_zero("reset_release");

    // ADD r3,r1,r2
    drive(1'b1, 0, 1, 2, 3);
    #1 check("add_stall", stall, 0);
    tick();
    check("add_ex_valid", ex_valid, 1);
    check("add_ex_alu_op", ex_alu_op, 0);
    check("add_ex_dst", ex_dst, 3);
    check("add_ex_alusrc", ex_alusrc, 0);
    drive(1'b0, 0, 0, 0, 0);
    tick();
    check("add_mem_valid", mem_valid, 1);
    check("add_mem_dst", mem_dst, 3);
    tick();
    check("add_wb_valid", wb_valid, 1);
    check("add_wb_regwrite", wb_regwrite, 1);
    check("add_wb_dst", wb_dst, 3);

    // LW r4,(r1) then ADD r5,r4,r1
    drive(1'b1, 7, 1, 4, 0);
    tick();
    check("lw_ex_memread", ex_memread, 1);
    check("lw_ex_dst", ex_dst, 4);
    check("lw_ex_alusrc", ex_alusrc, 1);
    drive(1'b1, 0, 4, 1, 5);
    #1 check("lu_stall", stall, 1);
    check("lu_flush", flush, 0);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_memread", ex_memread, 0);
    check("lu_stall_release", stall, 0);
    tick();
    check("lu_add_ex_valid", ex_valid, 1);
    check("lu_add_ex_dst", ex_dst, 5);
    check("lu_lw_wb_memtoreg", wb_memtoreg, 1);
    check("lu_lw_wb_dst", wb_dst, 4);
    drive(1'b0, 0, 0, 0, 0);
    tick();

    // LW r4 then SW rs=r4
    drive(1'b1, 7, 1, 4, 0);
    tick();
    drive(1'b1, 8, 4, 2, 0);
    #1 check("lw_sw_stall", stall, 1);
    drive(1'b0, 0, 0, 0, 0);
    tick();

    // LW r0 then ADD using r0: no interlock on r0
    drive(1'b1, 7, 1, 0, 0);
    tick();
    check("lw0_ex_dst", ex_dst, 0);
    drive(1'b1, 0, 0, 0, 6);
    #1 check("lw0_stall", stall, 0);
    tick();
    check("lw0_add_ex_valid", ex_valid, 1);
    drive(1'b0, 0, 0, 0, 0);
    tick();

    // BEQZ taken with ADD in ID
    drive(1'b1, 13, 1, 0, 0);
    tick();
    check("beqz_ex_branch", ex_branch, 1);
    check("beqz_ex_alu_op", ex_alu_op, 1);
    drive(1'b1, 0, 1, 2, 7);
    ex_br_taken = 1'b1;
    #1 check("br_flush", flush, 1);
    check("br_stall", stall, 0);
    tick();
    ex_br_taken = 1'b0;
    check("br_bubble_valid", ex_valid, 0);
    drive(1'b0, 0, 0, 0, 0);
    tick();

    // BEQZ taken with HLT in ID: HLT flushed, FSM stays RUN
    drive(1'b1, 13, 2, 0, 0);
    tick();
    drive(1'b1, 5, 0, 0, 0);
    ex_br_taken = 1'b1;
    #1 check("brhlt_flush", flush, 1);
    check("brhlt_stall", stall, 0);
    tick();
    ex_br_taken = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    #1 check("brhlt_run_stall", stall, 0);
    tick();
    check("brhlt_run_stall2", stall, 0);
    check("brhlt_halted", halted, 0);

    // ADDI r8 then ADDI r0
    drive(1'b1, 9, 1, 8, 0);
    tick();
    check("addi_ex_alusrc", ex_alusrc, 1);
    drive(1'b1, 9, 1, 0, 0);
    tick();
    drive(1'b0, 0, 0, 0, 0);
    tick();
    check("addi8_wb_regwrite", wb_regwrite, 1);
    check("addi8_wb_dst", wb_dst, 8);
    tick();
    check("addi0_wb_valid", wb_valid, 1);
    check("addi0_wb_regwrite", wb_regwrite, 0);

    // Undefined opcode 6
    drive(1'b1, 6, 1, 2, 3);
    tick();
    check("ill_pulse", illegal_op, 1);
    check("ill_ex_valid", ex_valid, 0);
    check("ill_ctrl", int'(ex_alu_op) + int'(ex_memread) + int'(ex_branch) + int'(ex_alusrc) + int'(ex_dst), 0);
    drive(1'b0, 0, 0, 0, 0);
    tick();
    check("ill_pulse_end", illegal_op, 0);

    // SUB r9 then HLT: drain and halt
    drive(1'b1, 1, 1, 2, 9);
    tick();
    check("sub_ex_alu_op", ex_alu_op, 1);
    drive(1'b1, 5, 0, 0, 0);
    #1 check("hlt_id_stall", stall, 0);
    tick();
    check("drain_stall", stall, 1);
    check("drain_ex_valid", ex_valid, 0);
    check("drain_mem_valid", mem_valid, 1);
    drive(1'b1, 0, 1, 2, 10);
    tick();
    check("drain_ignored_ex", ex_valid, 0);
    check("drain_wb_valid", wb_valid, 1);
    check("drain_halted_t3", halted, 0);
    tick();
    check("drain_wb_fall", wb_valid, 0);
    check("drain_halted_t4", halted, 0);
    check("drain_stall_t4", stall, 1);
    tick();
    check("halted_rise", halted, 1);
    check("halted_stall", stall, 1);
    tick();
    check("halted_ex_valid", ex_valid, 0);
    check("halted_wb_valid", wb_valid, 0);
    check("halted_sticky", halted, 1);

    // Async reset out of HALTED, then mid-stream
    #2 rst_n = 1'b0;
    #1 check("rst_halted", halted, 0);
    check("rst_stall", stall, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1'b1, 0, 1, 2, 3);
    tick();
    check("post_rst_ex_valid", ex_valid, 1);
    drive(1'b1, 7, 1, 4, 0);
    tick();
    check("mid_ex_memread", ex_memread, 1);
    check("mid_mem_valid", mem_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1'b0, 0, 0, 0, 0);
    tick();
    check("rel_stall", stall, 0);
    check("rel_halted", halted, 0);
    check("rel_wb_valid", wb_valid, 0);
    drive(1'b1, 0, 1, 2, 11);
    tick();
    check("rel_ex_valid", ex_valid, 1);
    check("rel_ex_dst", ex_dst, 11);
    drive(1'b0, 0, 0, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
